// File: rtl/mac_run_sequencer.sv
// Run-level sequencer for ma_control: per iteration it pulses aclr, then start,
// then waits for done under a watchdog, and accumulates pass/error/timeout statistics.
module mac_run_sequencer #(
    parameter int ITER_W      = 16,
    parameter int CNT_W       = 16,
    parameter int ACLR_CYCLES = 2,
    parameter int GAP_CYCLES  = 1,
    parameter int TIMEOUT     = 1024
) (
    input  logic              s_clk,
    input  logic              reset_in,
    input  logic              run_req,
    input  logic [ITER_W-1:0] iterations,
    input  logic              done,
    input  logic              check_ok,
    output logic              aclr,
    output logic              start,
    output logic              busy,
    output logic              run_done,
    output logic [ITER_W-1:0] iter_count,
    output logic [CNT_W-1:0]  err_count,
    output logic [CNT_W-1:0]  timeout_count,
    output logic [2:0]        dbg_state
);

    localparam int PH_MAX = (ACLR_CYCLES > GAP_CYCLES) ? ACLR_CYCLES : GAP_CYCLES;
    localparam int PH_W   = $clog2(PH_MAX + 1);
    localparam int WD_W   = $clog2(TIMEOUT);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CLR   = 3'd1,
        GAP   = 3'd2,
        START = 3'd3,
        WAIT  = 3'd4,
        CHECK = 3'd5,
        FIN   = 3'd6
    } state_t;

    state_t            state, state_nxt;
    logic [PH_W-1:0]   phase_cnt, phase_nxt;
    logic [WD_W-1:0]   wd_timer, wd_nxt;
    logic [ITER_W-1:0] target, target_nxt;
    logic              ok_q, ok_nxt;
    logic              to_q, to_nxt;
    logic              busy_nxt, run_done_nxt, aclr_nxt, start_nxt;
    logic [ITER_W-1:0] iter_nxt;
    logic [CNT_W-1:0]  err_nxt, tmo_nxt;

    assign dbg_state = state;

    always_comb begin
        state_nxt    = state;
        phase_nxt    = phase_cnt;
        wd_nxt       = wd_timer;
        target_nxt   = target;
        ok_nxt       = ok_q;
        to_nxt       = to_q;
        busy_nxt     = busy;
        run_done_nxt = run_done;
        iter_nxt     = iter_count;
        err_nxt      = err_count;
        tmo_nxt      = timeout_count;

        case (state)
            IDLE: begin
                if (run_req) begin
                    target_nxt   = iterations;
                    iter_nxt     = '0;
                    err_nxt      = '0;
                    tmo_nxt      = '0;
                    run_done_nxt = 1'b0;
                    busy_nxt     = 1'b1;
                    phase_nxt    = '0;
                    state_nxt    = CLR;
                end
            end
            CLR: begin
                if (phase_cnt == PH_W'(ACLR_CYCLES - 1)) begin
                    phase_nxt = '0;
                    state_nxt = GAP;
                end else begin
                    phase_nxt = phase_cnt + PH_W'(1);
                end
            end
            GAP: begin
                if (phase_cnt == PH_W'(GAP_CYCLES - 1)) begin
                    phase_nxt = '0;
                    state_nxt = START;
                end else begin
                    phase_nxt = phase_cnt + PH_W'(1);
                end
            end
            START: begin
                wd_nxt    = '0;
                state_nxt = WAIT;
            end
            WAIT: begin
                // done has priority over the watchdog on the final cycle
                if (done) begin
                    ok_nxt    = check_ok;
                    to_nxt    = 1'b0;
                    state_nxt = CHECK;
                end else if (wd_timer == WD_W'(TIMEOUT - 1)) begin
                    to_nxt    = 1'b1;
                    state_nxt = CHECK;
                end else begin
                    wd_nxt = wd_timer + WD_W'(1);
                end
            end
            CHECK: begin
                iter_nxt = iter_count + ITER_W'(1);
                if (to_q) begin
                    if (timeout_count != '1) tmo_nxt = timeout_count + CNT_W'(1);
                end else if (!ok_q) begin
                    if (err_count != '1) err_nxt = err_count + CNT_W'(1);
                end
                phase_nxt = '0;
                if (!run_req || (target != '0 && iter_nxt == target)) begin
                    state_nxt = FIN;
                end else begin
                    state_nxt = CLR;
                end
            end
            FIN: begin
                busy_nxt     = 1'b0;
                run_done_nxt = 1'b1;
                state_nxt    = IDLE;
            end
            default: state_nxt = IDLE;
        endcase

        aclr_nxt  = (state_nxt == CLR);
        start_nxt = (state_nxt == START);
    end

    always_ff @(posedge s_clk or posedge reset_in) begin
        if (reset_in) begin
            state         <= IDLE;
            phase_cnt     <= '0;
            wd_timer      <= '0;
            target        <= '0;
            ok_q          <= 1'b0;
            to_q          <= 1'b0;
            aclr          <= 1'b0;
            start         <= 1'b0;
            busy          <= 1'b0;
            run_done      <= 1'b0;
            iter_count    <= '0;
            err_count     <= '0;
            timeout_count <= '0;
        end else begin
            state         <= state_nxt;
            phase_cnt     <= phase_nxt;
            wd_timer      <= wd_nxt;
            target        <= target_nxt;
            ok_q          <= ok_nxt;
            to_q          <= to_nxt;
            aclr          <= aclr_nxt;
            start         <= start_nxt;
            busy          <= busy_nxt;
            run_done      <= run_done_nxt;
            iter_count    <= iter_nxt;
            err_count     <= err_nxt;
            timeout_count <= tmo_nxt;
        end
    end

endmodule

// File: tb/tb_mac_run_sequencer.sv
// Directed bench for mac_run_sequencer: reset/idle, basic run, errors, watchdog,
// free-run stop and asynchronous reset mid-clear.
module tb_mac_run_sequencer;

    localparam int ITER_W = 16;
    localparam int CNT_W  = 16;

    logic              s_clk;
    logic              reset_in;
    logic              run_req;
    logic [ITER_W-1:0] iterations;
    logic              done;
    logic              check_ok;
    logic              aclr;
    logic              start;
    logic              busy;
    logic              run_done;
    logic [ITER_W-1:0] iter_count;
    logic [CNT_W-1:0]  err_count;
    logic [CNT_W-1:0]  timeout_count;
    logic [2:0]        dbg_state;

    int tests = 0;
    int fails = 0;
    int start_cnt = 0;
    int pat_bad = 0;
    logic [3:0] hist = 4'b0000;

    mac_run_sequencer #(
        .ITER_W(ITER_W), .CNT_W(CNT_W), .ACLR_CYCLES(2), .GAP_CYCLES(1), .TIMEOUT(16)
    ) dut (
        .s_clk(s_clk), .reset_in(reset_in), .run_req(run_req), .iterations(iterations),
        .done(done), .check_ok(check_ok), .aclr(aclr), .start(start), .busy(busy),
        .run_done(run_done), .iter_count(iter_count), .err_count(err_count),
        .timeout_count(timeout_count), .dbg_state(dbg_state)
    );

    initial s_clk = 1'b0;
    always #5 s_clk = ~s_clk;

    // Every start pulse must follow exactly: idle/check, clr, clr, gap
    always @(negedge s_clk) begin
        if (start) begin
            start_cnt = start_cnt + 1;
            if (hist != 4'b0110) pat_bad = pat_bad + 1;
        end
        if (aclr && start) pat_bad = pat_bad + 1;
        hist = {hist[2:0], aclr};
    end

    task automatic tick();
        @(posedge s_clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_start(input string tag);
        logic found;
        found = 1'b0;
        for (int i = 0; i < 60 && !found; i++) begin
            tick();
            if (start) found = 1'b1;
        end
        check(tag, {31'd0, found}, 32'd1);
    endtask

    // Wait for start, then raise done for one cycle in the lat-th cycle after it
    task automatic do_iter(input string tag, input int lat, input logic ok);
        wait_start(tag);
        for (int i = 0; i < lat; i++) tick();
        done     = 1'b1;
        check_ok = ok;
        tick();
        done     = 1'b0;
        check_ok = 1'b1;
    endtask

    task automatic wait_fin(input string tag);
        logic found;
        found = 1'b0;
        for (int i = 0; i < 200 && !found; i++) begin
            tick();
            if (!busy) found = 1'b1;
        end
        check(tag, {31'd0, found}, 32'd1);
    endtask

    initial begin
        int base;
        int n;
        logic act;

        reset_in   = 1'b1;
        run_req    = 1'b0;
        iterations = '0;
        done       = 1'b0;
        check_ok   = 1'b1;

        // 1: reset then idle
        repeat (3) tick();
        reset_in = 1'b0;
        act = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            act = act | aclr | start | busy;
        end
        check("t1_activity", {31'd0, act}, 32'd0);
        check("t1_iter", 32'(iter_count), 32'd0);
        check("t1_err", 32'(err_count), 32'd0);
        check("t1_tmo", 32'(timeout_count), 32'd0);
        check("t1_run_done", {31'd0, run_done}, 32'd0);
        check("t1_state", 32'(dbg_state), 32'd0);

        // 2: basic run of 3 iterations
        base = start_cnt;
        iterations = 16'd3;
        run_req = 1'b1;
        tick();
        check("t2_busy_start", {31'd0, busy}, 32'd1);
        do_iter("t2_start1", 5, 1'b1);
        do_iter("t2_start2", 5, 1'b1);
        do_iter("t2_start3", 5, 1'b1);
        wait_fin("t2_fin");
        run_req = 1'b0;
        check("t2_pulses", 32'(start_cnt - base), 32'd3);
        check("t2_iter", 32'(iter_count), 32'd3);
        check("t2_err", 32'(err_count), 32'd0);
        check("t2_tmo", 32'(timeout_count), 32'd0);
        check("t2_run_done", {31'd0, run_done}, 32'd1);
        check("t2_busy", {31'd0, busy}, 32'd0);

        // 3: check_ok low on iterations 2 and 4
        iterations = 16'd4;
        run_req = 1'b1;
        tick();
        check("t3_run_done_clr", {31'd0, run_done}, 32'd0);
        do_iter("t3_start1", 3, 1'b1);
        do_iter("t3_start2", 4, 1'b0);
        do_iter("t3_start3", 2, 1'b1);
        do_iter("t3_start4", 6, 1'b0);
        wait_fin("t3_fin");
        run_req = 1'b0;
        check("t3_err", 32'(err_count), 32'd2);
        check("t3_iter", 32'(iter_count), 32'd4);
        check("t3_tmo", 32'(timeout_count), 32'd0);

        // 4a: watchdog, done never asserted
        iterations = 16'd2;
        run_req = 1'b1;
        tick();
        for (int k = 0; k < 2; k++) begin
            wait_start("t4_start");
            n = 0;
            for (int i = 0; i < 40; i++) begin
                tick();
                if (dbg_state == 3'd4) n++;
                else break;
            end
            check("t4_wait_len", 32'(n), 32'd16);
        end
        wait_fin("t4_fin");
        run_req = 1'b0;
        check("t4_tmo", 32'(timeout_count), 32'd2);
        check("t4_err", 32'(err_count), 32'd0);
        check("t4_iter", 32'(iter_count), 32'd2);

        // 4b: done on the 16th WAIT cycle is a done, not a timeout
        iterations = 16'd1;
        run_req = 1'b1;
        tick();
        do_iter("t4b_start", 16, 1'b1);
        wait_fin("t4b_fin");
        run_req = 1'b0;
        check("t4b_tmo", 32'(timeout_count), 32'd0);
        check("t4b_err", 32'(err_count), 32'd0);
        check("t4b_iter", 32'(iter_count), 32'd1);

        // 5: free-run, run_req dropped mid-WAIT of iteration 11
        base = start_cnt;
        iterations = 16'd0;
        run_req = 1'b1;
        tick();
        for (int k = 0; k < 10; k++) do_iter("t5_start", 3, 1'b1);
        wait_start("t5_start11");
        repeat (2) tick();
        run_req = 1'b0;
        repeat (2) tick();
        done = 1'b1;
        tick();
        done = 1'b0;
        wait_fin("t5_fin");
        check("t5_iter", 32'(iter_count), 32'd11);
        check("t5_run_done", {31'd0, run_done}, 32'd1);
        check("t5_pulses", 32'(start_cnt - base), 32'd11);
        done = 1'b1;
        check_ok = 1'b0;
        repeat (3) tick();
        done = 1'b0;
        check_ok = 1'b1;
        check("t5_spur_iter", 32'(iter_count), 32'd11);
        check("t5_spur_err", 32'(err_count), 32'd0);
        check("t5_spur_state", 32'(dbg_state), 32'd0);

        // 6: asynchronous reset while aclr is high
        iterations = 16'd5;
        run_req = 1'b1;
        tick();
        do_iter("t6_start1", 2, 1'b0);
        act = 1'b0;
        for (int i = 0; i < 10 && !act; i++) begin
            tick();
            if (aclr) act = 1'b1;
        end
        check("t6_aclr_seen", {31'd0, act}, 32'd1);
        check("t6_pre_err", 32'(err_count), 32'd1);
        check("t6_pre_iter", 32'(iter_count), 32'd1);
        #1;
        reset_in = 1'b1;
        #1;
        check("t6_aclr", {31'd0, aclr}, 32'd0);
        check("t6_busy", {31'd0, busy}, 32'd0);
        check("t6_iter", 32'(iter_count), 32'd0);
        check("t6_err", 32'(err_count), 32'd0);
        check("t6_state", 32'(dbg_state), 32'd0);
        repeat (2) tick();
        base = start_cnt;
        iterations = 16'd1;
        reset_in = 1'b0;
        do_iter("t6_restart", 3, 1'b1);
        wait_fin("t6_fin");
        run_req = 1'b0;
        check("t6_new_iter", 32'(iter_count), 32'd1);
        check("t6_new_err", 32'(err_count), 32'd0);
        check("t6_new_done", {31'd0, run_done}, 32'd1);
        check("t6_new_pulses", 32'(start_cnt - base), 32'd1);

        tick();
        check("aclr_gap_pattern", 32'(pat_bad), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/mac_run_sequencer.md
Name: mac_run_sequencer

Overview:
- Run-level controller for the MAC / ma_control datapath.
- Issues the per-iteration async-clear pulse and start pulse to ma_control, then waits for done.
- Repeats for a programmed number of iterations (or free-runs), applying a done-timeout watchdog.
- Accumulates pass, error and timeout statistics for display/readout on the demo board.

Parameters:
ITER_W, 16, width of iteration target and iteration counter
CNT_W, 16, width of error and timeout counters (saturating)
ACLR_CYCLES, 2, cycles aclr is held high per iteration (>=1)
GAP_CYCLES, 1, idle cycles between aclr release and start pulse (>=1)
TIMEOUT, 1024, max cycles waited for done after start (>=2)

Ports:
s_clk  in  1  system clock
reset_in  in  1  asynchronous, active-high reset
run_req  in  1  level; 1 = request/continue run
iterations  in  ITER_W  iterations per run; 0 = free-run until run_req drops; sampled at run start
done  in  1  done from ma_control
check_ok  in  1  result-check flag from datapath, valid in the cycle done=1
aclr  out  1  async clear to ma_control
start  out  1  start pulse to ma_control
busy  out  1  high from run start through FIN
run_done  out  1  sticky, set on run completion, cleared at next run start
iter_count  out  ITER_W  completed iterations this run (wraps in free-run)
err_count  out  CNT_W  iterations with done=1 and check_ok=0
timeout_count  out  CNT_W  iterations ended by watchdog

Behaviour:
- Reset: all outputs 0, state IDLE, internal timers 0, latched target 0. All outputs are registered and change only on s_clk edges.
- States: IDLE, CLR, GAP, START, WAIT, CHECK, FIN.
- IDLE:
  - If run_req=1: latch iterations; clear iter_count, err_count and timeout_count; clear run_done; set busy=1; go to CLR.
  - If run_req=0: stay in IDLE.
- CLR: aclr=1 for exactly ACLR_CYCLES cycles, then go to GAP.
- GAP: aclr=0 and start=0 for exactly GAP_CYCLES cycles, then go to START.
- START: start=1 for exactly one cycle; watchdog timer loaded to 0; go to WAIT.
- WAIT:
  - Timer increments each cycle.
  - done=1: capture check_ok; go to CHECK.
  - Timer reaches TIMEOUT-1 with done=0: mark timeout; go to CHECK.
  - done=1 on the timeout cycle counts as done, not as a timeout.
- CHECK (1 cycle):
  - iter_count += 1.
  - On timeout: timeout_count += 1.
  - Else, if captured check_ok=0: err_count += 1.
  - err_count and timeout_count saturate at all-ones. iter_count wraps only in free-run mode.
  - Next state is FIN if run_req=0, or if target!=0 and iter_count+1 == target; otherwise CLR.
- FIN (1 cycle): busy=0, run_done=1, go to IDLE. If run_req is still 1, IDLE immediately starts a new run on the following cycle.
- done outside WAIT is ignored. A done pulse lasting multiple cycles counts once, since CHECK leaves WAIT.
- Deasserting run_req mid-iteration does not abort it. The current iteration completes normally and the run ends at CHECK.
- Changing iterations mid-run has no effect until the next run start.
- reset_in mid-operation: immediate return to reset values, including aclr=0 and start=0. Counters are lost.
- Minimum iteration period is ACLR_CYCLES+GAP_CYCLES+1 (START) + 1 (min WAIT) + 1 (CHECK) cycles.

Test Plan:
1. Reset then idle: reset_in high 3 cycles, run_req=0 for 20 cycles -> all outputs 0, no aclr/start activity.
2. Basic run: iterations=3, run_req=1 held; responder raises done with check_ok=1 5 cycles after each start -> exactly 3 start pulses; each preceded by 2 aclr cycles and 1 gap cycle; final iter_count=3, err_count=0, timeout_count=0; run_done=1 and busy=0 after FIN.
3. Errors: iterations=4, check_ok=0 on iterations 2 and 4 -> err_count=2, iter_count=4, timeout_count=0.
4. Watchdog: TIMEOUT=16, iterations=2, done never asserted -> each WAIT lasts 16 cycles; timeout_count=2, err_count=0, iter_count=2. Second check: done on the 16th WAIT cycle counts as done.
5. Free-run stop: iterations=0, run_req high for 10 iterations then dropped mid-WAIT -> that iteration completes; iter_count=11; run_done=1. Spurious done in IDLE is ignored.
6. Reset mid-CLR: reset_in asserted while aclr=1 -> aclr, busy and counters go to 0 asynchronously. After release with run_req=1, a new run starts cleanly.
